// File: rtl/register_rename_table_pkg.sv
// Shared types and default sizes for the register rename table and its free list.
// Optional free-list checking is enabled by defining RENAME_FREELIST_CHECK_EN.
package register_rename_table_pkg;

    localparam int NUM_LOGICAL  = 32;
    localparam int NUM_PHYSICAL = 64;
    localparam int PW           = $clog2(NUM_PHYSICAL);
    localparam int LW           = 5;

    typedef logic [PW-1:0] PhysReg;
    typedef logic [LW-1:0] LogReg;

    typedef enum logic {
        NORMAL  = 1'b0,
        RESTORE = 1'b1
    } rename_state_t;

    typedef struct packed {
        LogReg  logical;
        PhysReg physical;
    } rename_pairing_t;

    // Logical register 0 is hardwired and never receives a new physical tag.
    function automatic logic is_renamed(input LogReg dst, input logic dst_wr);
        return dst_wr && (dst != '0);
    endfunction

endpackage

// File: rtl/register_rename_table_free_list.sv
// Circular FIFO of free physical tags, preloaded with the tags not mapped at reset.
// With RENAME_FREELIST_CHECK_EN defined, a free bitmap flags and drops illegal pushes/pops.
module register_rename_table_free_list #(
    parameter int NUM_LOGICAL  = 32,
    parameter int NUM_PHYSICAL = 64,
    localparam int PW          = $clog2(NUM_PHYSICAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [PW-1:0] push_tag,
    input  logic          pop,
    output logic [PW-1:0] head_tag,
    output logic          empty,
    output logic          err
);

    localparam int INIT_FREE = NUM_PHYSICAL - NUM_LOGICAL;

    logic [PW-1:0] mem [NUM_PHYSICAL];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign head_tag = mem[head];
    assign empty    = (count == '0);

`ifdef RENAME_FREELIST_CHECK_EN
    logic [NUM_PHYSICAL-1:0] free_map;
    logic                    full;
    logic                    bad_push;
    logic                    bad_pop;

    assign full     = (count == (PW+1)'(NUM_PHYSICAL));
    assign bad_push = push && (full || (push_tag == '0) || free_map[push_tag]);
    assign bad_pop  = pop && empty;
    assign push_ok  = push && !bad_push;
    assign pop_ok   = pop && !bad_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map <= {{INIT_FREE{1'b1}}, {NUM_LOGICAL{1'b0}}};
            err      <= 1'b0;
        end else begin
            if (bad_push || bad_pop)
                err <= 1'b1;
            if (pop_ok)
                free_map[head_tag] <= 1'b0;
            if (push_ok)
                free_map[push_tag] <= 1'b1;
        end
    end
`else
    assign push_ok = push;
    assign pop_ok  = pop;
    assign err     = 1'b0;
`endif

    // NOTE: the FIFO storage is reset too: its initial contents are the architectural
    // free tags, not don't-cares, so a storage array without reset would be wrong here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHYSICAL; i++)
                mem[i] <= (i < INIT_FREE) ? PW'(NUM_LOGICAL + i) : '0;
            head  <= '0;
            tail  <= PW'(INIT_FREE);
            count <= (PW+1)'(INIT_FREE);
        end else begin
            if (push_ok) begin
                mem[tail] <= push_tag;
                tail      <= tail + 1'b1;
            end
            if (pop_ok)
                head <= head + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/register_rename_table.sv
// Front-end rename: map table, free-list allocation, displaced-pairing output and flush walk-back.
// Free-list error checking is compiled in when RENAME_FREELIST_CHECK_EN is defined.
module register_rename_table #(
    parameter int NUM_LOGICAL  = 32,
    parameter int NUM_PHYSICAL = 64,
    localparam int PW          = $clog2(NUM_PHYSICAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ren_valid,
    output logic          o_ren_ready,
    input  logic [4:0]    i_src_a,
    input  logic [4:0]    i_src_b,
    input  logic [4:0]    i_dst,
    input  logic          i_dst_wr,
    output logic          o_out_valid,
    output logic [PW-1:0] o_phys_a,
    output logic [PW-1:0] o_phys_b,
    output logic [PW-1:0] o_phys_dst,
    output logic          o_add_mapping,
    output logic [4:0]    o_prev_logical,
    output logic [PW-1:0] o_prev_physical,
    input  logic          i_commit_free_valid,
    input  logic [PW-1:0] i_commit_free_phys,
    input  logic          i_flush,
    input  logic          i_restore_valid,
    output logic          o_restore_ready,
    input  logic [4:0]    i_restore_logical,
    input  logic [PW-1:0] i_restore_physical,
    input  logic [PW-1:0] i_restore_squashed,
    input  logic          i_restore_done,
    output logic          o_err
);

    import register_rename_table_pkg::*;

    rename_state_t   state;
    rename_pairing_t displaced;
    logic [PW-1:0]   map [NUM_LOGICAL];

    logic            accept;
    logic            alloc;
    logic            restore_accept;
    logic            fl_push;
    logic [PW-1:0]   fl_push_tag;
    logic [PW-1:0]   fl_head_tag;
    logic            fl_empty;

    assign o_ren_ready     = (state == NORMAL) && (!fl_empty || !i_dst_wr || (i_dst == '0));
    assign accept          = i_ren_valid && o_ren_ready;
    assign alloc           = accept && is_renamed(i_dst, i_dst_wr);

    // The free list takes one push per cycle; a commit free wins over a restore pairing.
    assign o_restore_ready = (state == RESTORE) && !i_commit_free_valid;
    assign restore_accept  = i_restore_valid && o_restore_ready;
    assign fl_push         = i_commit_free_valid || restore_accept;
    assign fl_push_tag     = i_commit_free_valid ? i_commit_free_phys : i_restore_squashed;

    register_rename_table_free_list #(
        .NUM_LOGICAL  (NUM_LOGICAL),
        .NUM_PHYSICAL (NUM_PHYSICAL)
    ) u_free_list (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fl_push),
        .push_tag (fl_push_tag),
        .pop      (alloc),
        .head_tag (fl_head_tag),
        .empty    (fl_empty),
        .err      (o_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORMAL;
        end else begin
            case (state)
                NORMAL:  if (i_flush) state <= RESTORE;
                RESTORE: if (!i_flush && i_restore_done) state <= NORMAL;
                default: state <= NORMAL;
            endcase
        end
    end

    // Rename and restore never coincide: allocation only happens in NORMAL, restore only in RESTORE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LOGICAL; i++)
                map[i] <= PW'(i);
        end else if (alloc) begin
            map[i_dst] <= fl_head_tag;
        end else if (restore_accept && (i_restore_logical != '0)) begin
            map[i_restore_logical] <= i_restore_physical;
        end
    end

    // NOTE: non-blocking assignments mean every map read below sees the value from before
    // this cycle's update, which is exactly why "add r1,r1,r2" reads the old r1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_out_valid   <= 1'b0;
            o_phys_a      <= '0;
            o_phys_b      <= '0;
            o_phys_dst    <= '0;
            o_add_mapping <= 1'b0;
            displaced     <= '0;
        end else begin
            o_out_valid   <= accept;
            o_phys_a      <= accept ? map[i_src_a] : '0;
            o_phys_b      <= accept ? map[i_src_b] : '0;
            o_phys_dst    <= alloc ? fl_head_tag : '0;
            o_add_mapping <= alloc;
            displaced     <= alloc ? '{logical: i_dst, physical: map[i_dst]} : '0;
        end
    end

    assign o_prev_logical  = displaced.logical;
    assign o_prev_physical = displaced.physical;

endmodule

// File: tb/tb_register_rename_table.sv
// Self-checking bench for register_rename_table: queue-based reference model plus scoreboard.
// Expectations follow the RENAME_FREELIST_CHECK_EN setting of the build.
module tb_register_rename_table;

    localparam int NL = 32;
    localparam int NP = 64;
    localparam int PW = $clog2(NP);

    logic          clk;
    logic          rst_n;
    logic          i_ren_valid;
    logic          o_ren_ready;
    logic [4:0]    i_src_a;
    logic [4:0]    i_src_b;
    logic [4:0]    i_dst;
    logic          i_dst_wr;
    logic          o_out_valid;
    logic [PW-1:0] o_phys_a;
    logic [PW-1:0] o_phys_b;
    logic [PW-1:0] o_phys_dst;
    logic          o_add_mapping;
    logic [4:0]    o_prev_logical;
    logic [PW-1:0] o_prev_physical;
    logic          i_commit_free_valid;
    logic [PW-1:0] i_commit_free_phys;
    logic          i_flush;
    logic          i_restore_valid;
    logic          o_restore_ready;
    logic [4:0]    i_restore_logical;
    logic [PW-1:0] i_restore_physical;
    logic [PW-1:0] i_restore_squashed;
    logic          i_restore_done;
    logic          o_err;

    register_rename_table dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_ren_valid         (i_ren_valid),
        .o_ren_ready         (o_ren_ready),
        .i_src_a             (i_src_a),
        .i_src_b             (i_src_b),
        .i_dst               (i_dst),
        .i_dst_wr            (i_dst_wr),
        .o_out_valid         (o_out_valid),
        .o_phys_a            (o_phys_a),
        .o_phys_b            (o_phys_b),
        .o_phys_dst          (o_phys_dst),
        .o_add_mapping       (o_add_mapping),
        .o_prev_logical      (o_prev_logical),
        .o_prev_physical     (o_prev_physical),
        .i_commit_free_valid (i_commit_free_valid),
        .i_commit_free_phys  (i_commit_free_phys),
        .i_flush             (i_flush),
        .i_restore_valid     (i_restore_valid),
        .o_restore_ready     (o_restore_ready),
        .i_restore_logical   (i_restore_logical),
        .i_restore_physical  (i_restore_physical),
        .i_restore_squashed  (i_restore_squashed),
        .i_restore_done      (i_restore_done),
        .o_err               (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;  int a; int b; int d; bit wr;
        bit cv; int cp;
        bit fl;
        bit rv; int rl; int rp; int rs; bit rd;
    } stim_t;

    typedef struct {
        int pa; int pb; int pd; bit add; int pl; int pp;
    } exp_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    // Reference model: architectural map, ordered free tags, displaced tags awaiting commit.
    int map_m[NL];
    int free_q[$];
    int pool_q[$];
    bit in_restore;
    bit err_m;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) map_m[i] = i;
        free_q.delete();
        for (int t = NL; t < NP; t++) free_q.push_back(t);
        pool_q.delete();
        in_restore = 0;
        err_m = 0;
    endfunction

    function automatic bit in_free(input int t);
        foreach (free_q[i]) if (free_q[i] == t) return 1;
        return 0;
    endfunction

    function automatic void free_push(input int t);
`ifdef RENAME_FREELIST_CHECK_EN
        if (free_q.size() == NP || t == 0 || in_free(t)) begin
            err_m = 1;
            return;
        end
`endif
        free_q.push_back(t);
    endfunction

    function automatic void pool_remove(input int t);
        foreach (pool_q[i])
            if (pool_q[i] == t) begin
                pool_q.delete(i);
                return;
            end
    endfunction

    function automatic int take_pool();
        int idx = $urandom_range(0, pool_q.size() - 1);
        int t = pool_q[idx];
        pool_q.delete(idx);
        return t;
    endfunction

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        return s;
    endfunction

    // One clock: drive at negedge, compare handshake outputs, advance the model, wait for posedge.
    task automatic drive(input stim_t s);
        bit   ready;
        bit   rready;
        exp_t e;
        @(negedge clk);
        i_ren_valid         = s.v;
        i_src_a             = 5'(s.a);
        i_src_b             = 5'(s.b);
        i_dst               = 5'(s.d);
        i_dst_wr            = s.wr;
        i_commit_free_valid = s.cv;
        i_commit_free_phys  = PW'(s.cp);
        i_flush             = s.fl;
        i_restore_valid     = s.rv;
        i_restore_logical   = 5'(s.rl);
        i_restore_physical  = PW'(s.rp);
        i_restore_squashed  = PW'(s.rs);
        i_restore_done      = s.rd;
        #1;
        ready  = !in_restore && (free_q.size() > 0 || !s.wr || s.d == 0);
        rready = in_restore && !s.cv;
        check("ren_ready", int'(o_ren_ready), int'(ready));
        check("restore_ready", int'(o_restore_ready), int'(rready));
        check("err", int'(o_err), int'(err_m));
        if (s.v && ready) begin
            e = '{default: 0};
            e.pa = map_m[s.a];
            e.pb = map_m[s.b];
            if (s.wr && s.d != 0) begin
                e.pd  = free_q.pop_front();
                e.add = 1;
                e.pl  = s.d;
                e.pp  = map_m[s.d];
                pool_q.push_back(e.pp);
                map_m[s.d] = e.pd;
            end
            sb.push_back(e);
        end
        if (s.cv) free_push(s.cp);
        if (s.rv && rready) begin
            if (s.rl != 0) map_m[s.rl] = s.rp;
            free_push(s.rs);
            pool_remove(s.rp);
            pool_remove(s.rs);
        end
        if (s.fl) in_restore = 1;
        else if (in_restore && s.rd) in_restore = 0;
        @(posedge clk);
    endtask

    task automatic rename(input int a, input int b, input int d, input bit wr);
        stim_t s = idle();
        s.v = 1; s.a = a; s.b = b; s.d = d; s.wr = wr;
        drive(s);
    endtask

    // Monitor: every rename result appears exactly one cycle after its accept.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 || o_out_valid) begin
            check("out_valid", int'(o_out_valid), int'(sb.size() > 0));
            if (sb.size() > 0 && o_out_valid) begin
                e = sb.pop_front();
                check("phys_a", int'(o_phys_a), e.pa);
                check("phys_b", int'(o_phys_b), e.pb);
                check("phys_dst", int'(o_phys_dst), e.pd);
                check("add_mapping", int'(o_add_mapping), int'(e.add));
                check("prev_logical", int'(o_prev_logical), e.pl);
                check("prev_physical", int'(o_prev_physical), e.pp);
            end else if (sb.size() > 0) begin
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        stim_t s;
        int    prev3, t1, t2;

        rst_n = 1'b0;
        i_ren_valid = 0; i_src_a = 0; i_src_b = 0; i_dst = 0; i_dst_wr = 0;
        i_commit_free_valid = 0; i_commit_free_phys = 0; i_flush = 0;
        i_restore_valid = 0; i_restore_logical = 0; i_restore_physical = 0;
        i_restore_squashed = 0; i_restore_done = 0;
        model_reset();
        #12;
        check("rst_out_valid", int'(o_out_valid), 0);
        check("rst_phys_dst", int'(o_phys_dst), 0);
        check("rst_add_mapping", int'(o_add_mapping), 0);
        check("rst_prev_physical", int'(o_prev_physical), 0);
        check("rst_ren_ready", int'(o_ren_ready), 1);
        check("rst_restore_ready", int'(o_restore_ready), 0);
        check("rst_err", int'(o_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First rename: dst r5, sources r5/r6.
        rename(5, 6, 5, 1);
        #1;
        check("first_phys_a", int'(o_phys_a), 5);
        check("first_phys_b", int'(o_phys_b), 6);
        check("first_phys_dst", int'(o_phys_dst), 32);
        check("first_prev_physical", int'(o_prev_physical), 5);

        // Drain the free list down to one entry (tags 33..62); r1 later displaces tag 40.
        for (int t = 33; t <= 62; t++)
            rename($urandom_range(0, NL - 1), $urandom_range(0, NL - 1), ((t - 32) % 8) + 1, 1);

        // Last pop (63) with a same-cycle commit free of 40.
        pool_remove(40);
        s = idle(); s.v = 1; s.d = 9; s.wr = 1; s.cv = 1; s.cp = 40;
        drive(s);
        #1 check("pop_with_push_dst", int'(o_phys_dst), 63);
        rename(0, 0, 10, 1);
        #1 check("pop_freed_40", int'(o_phys_dst), 40);
        s = idle(); s.d = 11; s.wr = 1;
        drive(s);
        #1 check("empty_ren_ready", int'(o_ren_ready), 0);
        rename(1, 2, 0, 1);
        #1 check("r0_dst_accepted", int'(o_out_valid), 1);
        check("r0_dst_no_mapping", int'(o_add_mapping), 0);

        // Free some tags, then rename r3 twice, flush and walk it back.
        for (int k = 0; k < 6; k++) begin
            s = idle(); s.cv = 1; s.cp = take_pool();
            drive(s);
        end
        prev3 = map_m[3];
        t1 = free_q[0];
        rename(1, 2, 3, 1);
        t2 = free_q[0];
        rename(3, 4, 3, 1);
        s = idle(); s.v = 1; s.a = 3; s.b = 3; s.fl = 1;
        drive(s);
        #1 check("flush_cycle_phys_a", int'(o_phys_a), t2);
        s = idle(); s.v = 1; s.d = 7; s.wr = 1;
        s.rv = 1; s.rl = 3; s.rp = t1; s.rs = t2; s.cv = 1; s.cp = take_pool();
        drive(s);
        #1 check("restore_blocks_rename", int'(o_out_valid), 0);
        s.v = 0; s.cv = 0;
        drive(s);
        s = idle(); s.rv = 1; s.rl = 3; s.rp = prev3; s.rs = t1; s.rd = 1;
        drive(s);
        drive(idle());
        rename(3, 0, 0, 0);
        #1 check("restored_map_r3", int'(o_phys_a), prev3);

        // Randomised traffic with commit frees drawn from displaced tags.
        for (int n = 0; n < 500; n++) begin
            s = idle();
            s.v  = ($urandom_range(0, 3) != 0);
            s.a  = $urandom_range(0, NL - 1);
            s.b  = $urandom_range(0, NL - 1);
            s.d  = $urandom_range(0, NL - 1);
            s.wr = ($urandom_range(0, 4) != 0);
            if (pool_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                s.cv = 1;
                s.cp = take_pool();
            end
            drive(s);
        end

        // Asynchronous reset while a result is being presented.
        rename(1, 2, 3, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(o_out_valid), 0);
        check("midrst_add_mapping", int'(o_add_mapping), 0);
        check("midrst_ren_ready", int'(o_ren_ready), 1);
        sb.delete();
        model_reset();
        #2 rst_n = 1'b1;

        // Double free of tag 50 after it has been allocated.
        for (int k = 0; k < 19; k++)
            rename(0, 0, (k % 8) + 1, 1);
        s = idle(); s.cv = 1; s.cp = 50;
        drive(s);
        drive(s);
        drive(idle());
`ifdef RENAME_FREELIST_CHECK_EN
        check("double_free_err", int'(o_err), 1);
`else
        check("double_free_err", int'(o_err), 0);
`endif
        for (int k = 0; k < 16; k++)
            rename(0, 0, (k % 8) + 1, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/register_rename_table.md
Name: register_rename_table

Overview:
- Front-end rename unit that is the producer side of the map-pairing protocol the active list consumes.
- Per instruction it:
  - translates source logical registers to physical registers;
  - allocates a new physical destination from a free list;
  - emits the displaced (prev_logical, prev_physical) pairing to the active list with add_mapping.
- On a flush it is the consumer of the pairings the active list walks back, restoring the map and reclaiming squashed physical registers.

Parameters:
- NUM_LOGICAL, 32, logical registers (MipsReg space)
- NUM_PHYSICAL, 64, physical registers; must be > NUM_LOGICAL and a power of 2
- PW, $clog2(NUM_PHYSICAL), physical tag width (derived, not overridable)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- i_ren_valid  in  1  instruction presented for rename
- o_ren_ready  out  1  rename can accept this cycle
- i_src_a  in  5  logical source A
- i_src_b  in  5  logical source B
- i_dst  in  5  logical destination
- i_dst_wr  in  1  instruction writes i_dst
- o_out_valid  out  1  registered rename result valid
- o_phys_a  out  PW  physical source A
- o_phys_b  out  PW  physical source B
- o_phys_dst  out  PW  newly allocated physical destination
- o_add_mapping  out  1  pairing valid to active list
- o_prev_logical  out  5  logical register being remapped
- o_prev_physical  out  PW  physical register previously mapped to o_prev_logical
- i_commit_free_valid  in  1  commit releases a physical register
- i_commit_free_phys  in  PW  released physical register
- i_flush  in  1  flush pulse from hazard control
- i_restore_valid  in  1  walked-back pairing present
- o_restore_ready  out  1  pairing accepted this cycle
- i_restore_logical  in  5  logical register to restore
- i_restore_physical  in  PW  old mapping to reinstate
- i_restore_squashed  in  PW  squashed physical register to return to the free list
- i_restore_done  in  1  active list head==tail, walk finished
- o_err  out  1  sticky free-list error (see Optional Feature)

Behaviour:

Reset:
- map[i]=i for i<NUM_LOGICAL.
- Free list holds NUM_LOGICAL..NUM_PHYSICAL-1 in ascending order; count=NUM_PHYSICAL-NUM_LOGICAL.
- State=NORMAL.
- All outputs 0 except o_ren_ready=1.

State machine, NORMAL:
- o_ren_ready = (free count>0 || !i_dst_wr || i_dst==0).
- Accept when i_ren_valid && o_ren_ready.

Rename (1-cycle latency):
- An accept in cycle N produces in cycle N+1:
  - o_out_valid=1;
  - phys_a/phys_b read from the map as of cycle N, before this instruction's own dst update, so "add r1,r1,r2" sees the old r1.
- If i_dst_wr && i_dst!=0:
  - pop free-list head into o_phys_dst;
  - map[i_dst]<=popped tag;
  - o_add_mapping=1 with o_prev_logical=i_dst and o_prev_physical=old map[i_dst].
- Otherwise o_add_mapping=0 and o_phys_dst=0.
- Logical 0 is never renamed.
- Back-to-back accepts: instruction N+1 sees N's map update.

Free list:
- Circular FIFO of depth NUM_PHYSICAL with head/tail wrap modulo NUM_PHYSICAL.
- A push and a pop in the same cycle leave the count unchanged.
- Commit frees push in both states.

Flush:
- i_flush in any state moves to RESTORE next cycle.
- A rename accepted in the flush cycle still completes its output.

State machine, RESTORE:
- o_ren_ready=0.
- o_restore_ready = !i_commit_free_valid (one free-list push per cycle; a commit free has priority).
- Each accepted pairing:
  - map[i_restore_logical]<=i_restore_physical;
  - push i_restore_squashed.
- Pairings arrive youngest-first, so the last write wins naturally.
- i_restore_done moves to NORMAL next cycle.
- A pairing presented in the same cycle as done is accepted first.

Reset mid-operation:
- Asynchronous return to reset state from any state.
- Any outstanding o_out_valid is dropped.

Optional Feature:
- RENAME_FREELIST_CHECK_EN defined:
  - o_err sets (sticky until reset) on push when count==NUM_PHYSICAL, pop when count==0, push of tag 0, or push of a tag already marked free;
  - a NUM_PHYSICAL-bit free bitmap is kept for this;
  - the offending push is dropped.
- Undefined: no bitmap; o_err tied 0; pushes unchecked.

Decomposition:
- Shared package entries:
  - PhysReg typedef (logic [PW-1:0]);
  - NUM_PHYSICAL constant;
  - rename_state_t enum {NORMAL, RESTORE};
  - rename_pairing_t struct {logical, physical}.
- Sub-module rename_free_list: push/pop FIFO with count, full/empty flags, and the optional check logic.
- Map table and FSM stay in the top.

Test Plan:
- Reset, rename dst=r5, src=r5/r6 -> next cycle phys_a=5, phys_b=6, phys_dst=32, add_mapping=1, prev=(5,5); map[5]=32.
- 32 consecutive dst-writing renames with no frees -> tags 32..63 in order, then o_ren_ready=0; a rename with dst=r0 still accepted with add_mapping=0.
- Commit free of 40 in the same cycle as a rename pop at count=1 -> pop succeeds (tag 63), count stays 1, next pop returns 40.
- Rename r3->32 then r3->33, flush, restore pairings (3,32,sq=33) then (3,3,sq=32), done -> map[3]=3, 32 and 33 back in the free list, NORMAL after 1 cycle.
- i_commit_free_valid during restore -> o_restore_ready=0 that cycle, pairing held and accepted the next cycle.
- With RENAME_FREELIST_CHECK_EN: free tag 50 twice -> o_err=1 after the second push, count unchanged by it; without the macro o_err stays 0.
